unidade_bcd_input: RTL and testbench

- Input-side counterpart of the PC decimal display path: converts two BCD digits from board switches into a binary value for the CPU.
- A raw confirm push-button is synchronized and debounced. On a confirmed press, the block latches dezena*10+unidade.
- The latched value is presented to the CPU through a valid/read handshake. Non-BCD switch settings are flagged.
- Sits between the board I/O pins and the CPU input-instruction data path.

---
 rtl/unidade_bcd_input.sv | 137 +++++++++++++
 tb/tb_unidade_bcd_input.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_bcd_input.sv
// Board-switch BCD input unit: debounces the confirm button, converts two BCD
// digits to binary and offers the result to the CPU through a valid/read handshake.
module unidade_bcd_input #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            Switch_Unidade,
  input  logic [3:0]            Switch_Dezena,
  input  logic                  Botao,
  input  logic                  Ler,
  output logic [DATA_WIDTH-1:0] Dado,
  output logic                  Valido,
  output logic                  Erro
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned VAL_W = 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_CAPTURE,
    S_DEB_RELEASE
  } state_t;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_b_sync;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_dado;
  logic [DATA_WIDTH-1:0] w_dado_nxt;
  logic                  r_valido;
  logic                  w_valido_nxt;
  logic                  r_erro;
  logic                  w_erro_nxt;
  logic                  w_digits_ok;
  logic [VAL_W-1:0]      w_valor;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= Botao;
      r_sync2 <= r_sync1;
    end
  end

  assign w_b_sync    = r_sync2;
  assign w_digits_ok = (Switch_Dezena <= 4'd9) && (Switch_Unidade <= 4'd9);
  assign w_valor     = VAL_W'(Switch_Dezena) * VAL_W'(10) + VAL_W'(Switch_Unidade);

  // State, debounce counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dado   <= '0;
      r_valido <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dado   <= w_dado_nxt;
      r_valido <= w_valido_nxt;
      r_erro   <= w_erro_nxt;
    end
  end

  // Next-state logic; a valid capture overrides a simultaneous read
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dado_nxt   = r_dado;
    w_valido_nxt = r_valido;
    w_erro_nxt   = r_erro;

    if (Ler && r_valido) begin
      w_valido_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_b_sync) begin
          w_state_nxt = S_DEB_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_DEB_PRESS: begin
        if (!w_b_sync) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_DEB_RELEASE;
        w_cnt_nxt   = '0;
        if (w_digits_ok) begin
          w_dado_nxt   = DATA_WIDTH'(w_valor);
          w_valido_nxt = 1'b1;
          w_erro_nxt   = 1'b0;
        end else begin
          w_erro_nxt = 1'b1;
        end
      end
      S_DEB_RELEASE: begin
        if (w_b_sync) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign Dado   = r_dado;
  assign Valido = r_valido;
  assign Erro   = r_erro;

endmodule

// File: tb/tb_unidade_bcd_input.sv
// Directed bench for unidade_bcd_input with DEBOUNCE_CYCLES=4 and DATA_WIDTH=32.
module tb_unidade_bcd_input;

  logic        clock;
  logic        reset;
  logic [3:0]  Switch_Unidade;
  logic [3:0]  Switch_Dezena;
  logic        Botao;
  logic        Ler;
  logic [31:0] Dado;
  logic        Valido;
  logic        Erro;

  int n_checks = 0;
  int n_pass   = 0;

  unidade_bcd_input #(
    .DATA_WIDTH      (32),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .Switch_Unidade (Switch_Unidade),
    .Switch_Dezena  (Switch_Dezena),
    .Botao          (Botao),
    .Ler            (Ler),
    .Dado           (Dado),
    .Valido         (Valido),
    .Erro           (Erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive switches and raise the button; the next rising edge is edge 0
  task automatic press(input logic [3:0] dez, input logic [3:0] uni);
    Switch_Dezena  = dez;
    Switch_Unidade = uni;
    Botao          = 1'b1;
  endtask

  // Drop the button and let the release debounce return the FSM to idle
  task automatic release_btn();
    Botao = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Botao = 1'b0;
    Ler   = 1'b0;
    Switch_Dezena  = 4'd0;
    Switch_Unidade = 4'd0;
    step(2);
    n_checks++; if (Dado !== 32'd0)  $display("FAIL rst_dado: got %0d expected 0", Dado);   else n_pass++;
    n_checks++; if (Valido !== 1'b0) $display("FAIL rst_valido: got %0b expected 0", Valido); else n_pass++;
    n_checks++; if (Erro !== 1'b0)   $display("FAIL rst_erro: got %0b expected 0", Erro);     else n_pass++;
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_basic_capture();
    press(4'd4, 4'd7);
    step(7);
    n_checks++; if (Valido !== 1'b0) $display("FAIL lat_pre_valido: got %0b expected 0", Valido); else n_pass++;
    step(1);
    n_checks++; if (Valido !== 1'b1) $display("FAIL lat_valido: got %0b expected 1", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd47) $display("FAIL cap47_dado: got %0d expected 47", Dado); else n_pass++;
    n_checks++; if (Erro !== 1'b0)   $display("FAIL cap47_erro: got %0b expected 0", Erro);  else n_pass++;
    Switch_Dezena  = 4'd1;
    Switch_Unidade = 4'd1;
    step(2);
    Ler = 1'b1;
    step(1);
    Ler = 1'b0;
    n_checks++; if (Valido !== 1'b0) $display("FAIL ler_clear: got %0b expected 0", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd47) $display("FAIL ler_hold_dado: got %0d expected 47", Dado); else n_pass++;
    step(9);
    n_checks++; if (Valido !== 1'b0) $display("FAIL held_one_capture_valido: got %0b expected 0", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd47) $display("FAIL held_one_capture_dado: got %0d expected 47", Dado); else n_pass++;
    release_btn();
  endtask

  task automatic test_bounce();
    int hi [5] = '{1, 2, 3, 2, 1};
    int lo [5] = '{1, 2, 1, 2, 2};
    Switch_Dezena  = 4'd8;
    Switch_Unidade = 4'd5;
    for (int k = 0; k < 5; k++) begin
      Botao = 1'b1;
      step(hi[k]);
      Botao = 1'b0;
      step(lo[k]);
    end
    step(4);
    n_checks++; if (Valido !== 1'b0) $display("FAIL bounce_no_capture: got %0b expected 0", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd47) $display("FAIL bounce_dado: got %0d expected 47", Dado); else n_pass++;
    press(4'd8, 4'd5);
    step(7);
    n_checks++; if (Valido !== 1'b0) $display("FAIL bounce_lat_pre: got %0b expected 0", Valido); else n_pass++;
    step(1);
    n_checks++; if (Valido !== 1'b1) $display("FAIL bounce_lat_valido: got %0b expected 1", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd85) $display("FAIL bounce_dado85: got %0d expected 85", Dado); else n_pass++;
    release_btn();
  endtask

  task automatic test_boundaries();
    logic [24:0] upper;
    press(4'd9, 4'd9);
    step(8);
    upper = Dado[31:7];
    n_checks++; if (Dado !== 32'd99)   $display("FAIL max_dado: got %0d expected 99", Dado); else n_pass++;
    n_checks++; if (upper !== 25'd0)   $display("FAIL max_upper_bits: got %0h expected 0", upper); else n_pass++;
    release_btn();
    press(4'd0, 4'd0);
    step(8);
    n_checks++; if (Dado !== 32'd0)  $display("FAIL zero_dado: got %0d expected 0", Dado); else n_pass++;
    n_checks++; if (Valido !== 1'b1) $display("FAIL zero_valido: got %0b expected 1", Valido); else n_pass++;
    release_btn();
  endtask

  task automatic test_invalid();
    press(4'd4, 4'd7);
    step(8);
    n_checks++; if (Dado !== 32'd47) $display("FAIL inv_setup_dado: got %0d expected 47", Dado); else n_pass++;
    release_btn();
    press(4'hA, 4'd3);
    step(8);
    n_checks++; if (Erro !== 1'b1)   $display("FAIL inv_erro: got %0b expected 1", Erro);    else n_pass++;
    n_checks++; if (Dado !== 32'd47) $display("FAIL inv_dado_kept: got %0d expected 47", Dado); else n_pass++;
    n_checks++; if (Valido !== 1'b1) $display("FAIL inv_valido_kept: got %0b expected 1", Valido); else n_pass++;
    release_btn();
    Ler = 1'b1;
    step(1);
    Ler = 1'b0;
    n_checks++; if (Valido !== 1'b0) $display("FAIL inv_ler_valido: got %0b expected 0", Valido); else n_pass++;
    n_checks++; if (Erro !== 1'b1)   $display("FAIL inv_erro_sticky: got %0b expected 1", Erro); else n_pass++;
    press(4'd1, 4'd2);
    step(8);
    n_checks++; if (Dado !== 32'd12) $display("FAIL recover_dado: got %0d expected 12", Dado); else n_pass++;
    n_checks++; if (Erro !== 1'b0)   $display("FAIL recover_erro: got %0b expected 0", Erro); else n_pass++;
    n_checks++; if (Valido !== 1'b1) $display("FAIL recover_valido: got %0b expected 1", Valido); else n_pass++;
    release_btn();
  endtask

  task automatic test_back_to_back();
    press(4'd3, 4'd6);
    step(8);
    n_checks++; if (Dado !== 32'd36) $display("FAIL overwrite_dado: got %0d expected 36", Dado); else n_pass++;
    n_checks++; if (Valido !== 1'b1) $display("FAIL overwrite_valido: got %0b expected 1", Valido); else n_pass++;
    release_btn();
    press(4'd5, 4'd5);
    step(7);
    Ler = 1'b1;
    step(1);
    Ler = 1'b0;
    n_checks++; if (Valido !== 1'b1) $display("FAIL cap_vs_ler_valido: got %0b expected 1", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd55) $display("FAIL cap_vs_ler_dado: got %0d expected 55", Dado); else n_pass++;
    Ler = 1'b1;
    step(1);
    n_checks++; if (Valido !== 1'b0) $display("FAIL multi_ler_first: got %0b expected 0", Valido); else n_pass++;
    step(2);
    n_checks++; if (Valido !== 1'b0) $display("FAIL multi_ler_hold: got %0b expected 0", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd55) $display("FAIL multi_ler_dado: got %0d expected 55", Dado); else n_pass++;
    Ler = 1'b0;
    release_btn();
  endtask

  task automatic test_async_reset();
    press(4'd6, 4'd1);
    step(4);
    reset = 1'b1;
    #1;
    n_checks++; if (Dado !== 32'd0)  $display("FAIL arst_press_dado: got %0d expected 0", Dado); else n_pass++;
    n_checks++; if (Valido !== 1'b0) $display("FAIL arst_press_valido: got %0b expected 0", Valido); else n_pass++;
    Botao = 1'b0;
    #1;
    reset = 1'b0;
    step(2);
    press(4'd7, 4'd2);
    step(8);
    n_checks++; if (Dado !== 32'd72) $display("FAIL arst_setup_dado: got %0d expected 72", Dado); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (Dado !== 32'd0)  $display("FAIL arst_valid_dado: got %0d expected 0", Dado); else n_pass++;
    n_checks++; if (Valido !== 1'b0) $display("FAIL arst_valid_valido: got %0b expected 0", Valido); else n_pass++;
    n_checks++; if (Erro !== 1'b0)   $display("FAIL arst_valid_erro: got %0b expected 0", Erro); else n_pass++;
    Botao = 1'b0;
    #1;
    reset = 1'b0;
    step(2);
    press(4'd2, 4'd1);
    step(7);
    n_checks++; if (Valido !== 1'b0) $display("FAIL fresh_lat_pre: got %0b expected 0", Valido); else n_pass++;
    step(1);
    n_checks++; if (Valido !== 1'b1) $display("FAIL fresh_valido: got %0b expected 1", Valido); else n_pass++;
    n_checks++; if (Dado !== 32'd21) $display("FAIL fresh_dado: got %0d expected 21", Dado); else n_pass++;
    release_btn();
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_bounce();
    test_boundaries();
    test_invalid();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
